imm_extend_unit: RTL and testbench
==================================

Name: imm_extend_unit

Overview:
Parametrised, pipelined immediate-extension unit for the processor's decode/execute path. It generalises fixed 8-bit sign extension in four ways:
- input and output widths are parameters;
- the field width is selected at run time (sign-bit index);
- it has four extension modes;
- it has a registered valid/ready output with a 2-entry skid buffer, so it can sit between pipeline stages without breaking throughput.

Parameters:
- IN_W, 9, width of in_imm bus; must be ≥ 2.
- OUT_W, 16, width of out_data; must be ≥ IN_W.
- SHL, 1, left-shift amount applied in SEXT_SHL mode; 0 ≤ SHL < OUT_W.
- MSB_W, $clog2(IN_W), width of in_msb.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_imm  in  IN_W  raw immediate field (bits above in_msb are don't-care).
- in_msb  in  MSB_W  index of the field's top (sign) bit.
- in_mode  in  2  00 SEXT, 01 ZEXT, 10 SEXT_SHL, 11 UPPER.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_W  extended result.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: out_valid=0, out_data=0, skid entry empty, in_ready=1. Requests presented in any cycle with rst_n=0 are discarded.
- Handshake transfers:
  - Input transfer happens on a cycle with in_valid & in_ready.
  - Output transfer happens on a cycle with out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Latency is 1 cycle: an accepted request appears on out_data on the next clock.
  - Sustained throughput is 1/cycle while out_ready=1.
  - Order is strictly preserved; no loss, no duplication.
- in_ready is registered: in_ready = !skid_valid. It never depends combinationally on out_ready.
- Buffer states: EMPTY (no valid entries), ONE (main valid), FULL (main + skid valid).
  - EMPTY: accept → ONE.
  - ONE: accept & no drain → FULL (new word into skid). Accept & drain → ONE (new word into main). Drain only → EMPTY.
  - FULL: in_ready=0. Drain → ONE (skid moves to main). Otherwise stay FULL.
- Field clamp: f = min(in_msb, IN_W-1). Only in_imm[f:0] is used.
- Mode SEXT: out[f:0] = in_imm[f:0]; out[OUT_W-1:f+1] = in_imm[f].
- Mode ZEXT: same low bits; upper bits = 0.
- Mode SEXT_SHL: SEXT result shifted left by SHL, zero-filled, truncated to OUT_W. Overflowed bits are discarded silently.
- Mode UPPER: out[OUT_W-1 : OUT_W-1-f] = in_imm[f:0]; remaining low bits = 0.
- Edge case: f = OUT_W-1 in SEXT/ZEXT means no extension; the field passes through.
- Computation is combinational on the input side; results are registered into main/skid. No arithmetic is done on the output side.
- Reset mid-operation: with rst_n=0 in any state, the next cycle shows EMPTY, out_valid=0, in_ready=1. Buffered words are dropped.

Decomposition:
- Shared package proc_pkg holds:
  - the mode encodings (IMM_SEXT=2'b00, IMM_ZEXT=2'b01, IMM_SEXT_SHL=2'b10, IMM_UPPER=2'b11);
  - a typedef imm_mode_t;
  - the buffer state encoding.
- Natural sub-module: imm_skid_buffer, a generic WIDTH-parametrised 2-entry valid/ready skid buffer.
- The extension logic stays in imm_extend_unit as a combinational function feeding the buffer.

Test Plan:
- Basic SEXT/ZEXT: IN_W=9, OUT_W=16, out_ready=1, in_imm=9'h08F, in_msb=7.
  - SEXT → out_data=16'hFF8F one cycle later.
  - ZEXT → 16'h008F.
- Full field: in_msb=8.
  - SEXT 9'h0FF → 16'h00FF.
  - SEXT 9'h1FF → 16'hFFFF.
  - in_msb=15 (clamped to 8) with 9'h1FF → 16'hFFFF.
- Shift and upper modes: SHL=1, in_msb=7.
  - SEXT_SHL 9'h080 → 16'hFF00.
  - UPPER 9'h012 → 16'h1200.
  - UPPER 9'h0FF → 16'hFF00.
- Backpressure:
  - Hold out_ready=0 and stream A=9'h001, B=9'h002, C=9'h003 (SEXT, msb=7) → A and B accepted, then in_ready=0 with C held.
  - Release out_ready → outputs 16'h0001, 16'h0002, 16'h0003 in order, one per cycle, out_data stable while stalled.
- Reset in FULL: with the buffer FULL, pulse rst_n=0 for one cycle → next cycle out_valid=0, in_ready=1; the next accepted request emerges alone and correct.
- Throughput: 16 back-to-back requests with out_ready=1 → 16 results on 16 consecutive cycles, in_ready never drops.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: immediate extension modes and the
// occupancy encoding of the 2-entry skid buffer.
package proc_pkg;

    typedef enum logic [1:0] {
        IMM_SEXT     = 2'b00,
        IMM_ZEXT     = 2'b01,
        IMM_SEXT_SHL = 2'b10,
        IMM_UPPER    = 2'b11
    } imm_mode_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_t;

endpackage

// File: rtl/imm_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer. in_ready and out_valid are both
// registered, so neither side sees a combinational path from the other.
module imm_skid_buffer
    import proc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_t       state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             outValid_q;
    logic             inReady_q;

    logic accept;
    logic drain;

    assign accept = in_valid & inReady_q;
    assign drain  = outValid_q & out_ready;

    // main_q always holds the oldest word; skid_q only catches the word that
    // arrives while main_q is stalled, which keeps order without a pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_q     <= in_data;
                        state_q    <= BUF_ONE;
                        outValid_q <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && !drain) begin
                        skid_q    <= in_data;
                        state_q   <= BUF_FULL;
                        inReady_q <= 1'b0;
                    end else if (accept && drain) begin
                        main_q <= in_data;
                    end else if (drain) begin
                        state_q    <= BUF_EMPTY;
                        outValid_q <= 1'b0;
                    end
                end
                BUF_FULL: begin
                    if (drain) begin
                        main_q    <= skid_q;
                        state_q   <= BUF_ONE;
                        inReady_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= BUF_EMPTY;
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate-extension unit: a run-time-sized field is extended
// combinationally and the result is registered through a skid buffer.
module imm_extend_unit
    import proc_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 16,
    parameter int SHL   = 1,
    parameter int MSB_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [MSB_W-1:0] in_msb,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    // UPPER is the zero-extended field shifted so its top bit lands at OUT_W-1.
    function automatic logic [OUT_W-1:0] extend(
        input logic [IN_W-1:0]  imm,
        input logic [MSB_W-1:0] msb,
        input imm_mode_t        mode
    );
        int               f;
        logic             signBit;
        logic [OUT_W-1:0] zext;
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] result;

        f       = (int'(msb) > IN_W - 1) ? IN_W - 1 : int'(msb);
        signBit = imm[f];
        zext    = OUT_W'(imm);
        sext    = OUT_W'(imm);
        for (int i = 0; i < OUT_W; i++) begin
            if (i > f) begin
                zext[i] = 1'b0;
                sext[i] = signBit;
            end
        end

        case (mode)
            IMM_SEXT:     result = sext;
            IMM_ZEXT:     result = zext;
            IMM_SEXT_SHL: result = sext << SHL;
            IMM_UPPER:    result = zext << (OUT_W - 1 - f);
            default:      result = sext;
        endcase
        return result;
    endfunction

    logic [OUT_W-1:0] extData_d;

    assign extData_d = extend(in_imm, in_msb, imm_mode_t'(in_mode));

    imm_skid_buffer #(
        .WIDTH(OUT_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (extData_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed vector table plus
// backpressure, reset-while-full and back-to-back throughput sequences.
module tb_imm_extend_unit;

    localparam int IN_W  = 9;
    localparam int OUT_W = 16;
    localparam int MSB_W = 4;
    localparam int NV    = 15;

    typedef struct {
        logic [IN_W-1:0]  imm;
        logic [MSB_W-1:0] msb;
        logic [1:0]       mode;
        logic [OUT_W-1:0] expData;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [IN_W-1:0]  inImm;
    logic [MSB_W-1:0] inMsb;
    logic [1:0]       inMode;
    logic             outValid;
    logic             outReady;
    logic [OUT_W-1:0] outData;

    int   testsRun;
    int   testsFailed;
    vec_t vecs[NV];

    imm_extend_unit #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHL  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inValid),
        .in_ready (inReady),
        .in_imm   (inImm),
        .in_msb   (inMsb),
        .in_mode  (inMode),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_data (outData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [OUT_W-1:0] actual,
                               input logic [OUT_W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present one request at the falling edge; it is accepted on the next rising edge.
    task automatic applyStimulus(input logic [IN_W-1:0] imm, input logic [MSB_W-1:0] msb,
                                 input logic [1:0] mode);
        @(negedge clk);
        inValid = 1'b1;
        inImm   = imm;
        inMsb   = msb;
        inMode  = mode;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        inValid     = 1'b1;
        inImm       = 9'h0AA;
        inMsb       = 4'd7;
        inMode      = 2'b00;
        outReady    = 1'b1;

        vecs[0]  = '{9'h08F, 4'd7,  2'b00, 16'hFF8F};
        vecs[1]  = '{9'h08F, 4'd7,  2'b01, 16'h008F};
        vecs[2]  = '{9'h0FF, 4'd8,  2'b00, 16'h00FF};
        vecs[3]  = '{9'h1FF, 4'd8,  2'b00, 16'hFFFF};
        vecs[4]  = '{9'h1FF, 4'd15, 2'b00, 16'hFFFF};
        vecs[5]  = '{9'h080, 4'd7,  2'b10, 16'hFF00};
        vecs[6]  = '{9'h012, 4'd7,  2'b11, 16'h1200};
        vecs[7]  = '{9'h0FF, 4'd7,  2'b11, 16'hFF00};
        vecs[8]  = '{9'h1FF, 4'd8,  2'b01, 16'h01FF};
        vecs[9]  = '{9'h001, 4'd0,  2'b00, 16'hFFFF};
        vecs[10] = '{9'h1FE, 4'd0,  2'b01, 16'h0000};
        vecs[11] = '{9'h100, 4'd8,  2'b10, 16'hFE00};
        vecs[12] = '{9'h1FF, 4'd8,  2'b11, 16'hFF80};
        vecs[13] = '{9'h001, 4'd0,  2'b11, 16'h8000};
        vecs[14] = '{9'h17F, 4'd7,  2'b00, 16'h007F};

        // Reset with a request pending: it must be discarded.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", {15'd0, outValid}, 16'd0);
        checkOutput("reset out_data", outData, 16'h0000);
        checkOutput("reset in_ready", {15'd0, inReady}, 16'd1);
        @(negedge clk);
        inValid = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].imm, vecs[i].msb, vecs[i].mode);
            @(posedge clk);
            #1;
            inValid = 1'b0;
            checkOutput($sformatf("vec%0d valid", i), {15'd0, outValid}, 16'd1);
            checkOutput($sformatf("vec%0d data", i), outData, vecs[i].expData);
        end
        @(posedge clk);
        #1;
        checkOutput("table drained", {15'd0, outValid}, 16'd0);

        // Backpressure: A and B fill the buffer, C is held off.
        outReady = 1'b0;
        applyStimulus(9'h001, 4'd7, 2'b00);
        applyStimulus(9'h002, 4'd7, 2'b00);
        applyStimulus(9'h003, 4'd7, 2'b00);
        checkOutput("bp in_ready full", {15'd0, inReady}, 16'd0);
        checkOutput("bp stall data A", outData, 16'h0001);
        @(negedge clk);
        checkOutput("bp in_ready still", {15'd0, inReady}, 16'd0);
        checkOutput("bp stable A", outData, 16'h0001);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp data B", outData, 16'h0002);
        checkOutput("bp valid B", {15'd0, outValid}, 16'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkOutput("bp data C", outData, 16'h0003);
        checkOutput("bp valid C", {15'd0, outValid}, 16'd1);
        @(posedge clk);
        #1;
        checkOutput("bp drained", {15'd0, outValid}, 16'd0);

        // Reset while FULL drops both words.
        outReady = 1'b0;
        applyStimulus(9'h005, 4'd7, 2'b00);
        applyStimulus(9'h006, 4'd7, 2'b00);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("rf full in_ready", {15'd0, inReady}, 16'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rf out_valid", {15'd0, outValid}, 16'd0);
        checkOutput("rf in_ready", {15'd0, inReady}, 16'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        outReady = 1'b1;
        applyStimulus(9'h07F, 4'd7, 2'b00);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkOutput("rf after data", outData, 16'h007F);
        checkOutput("rf after valid", {15'd0, outValid}, 16'd1);
        @(posedge clk);
        #1;
        checkOutput("rf alone", {15'd0, outValid}, 16'd0);

        // Back-to-back throughput: one result per cycle, in_ready never drops.
        for (int i = 0; i < 16; i++) begin
            logic [7:0]       v8;
            logic [OUT_W-1:0] expV;
            v8   = 8'(i * 9);
            expV = {{8{v8[7]}}, v8};
            @(negedge clk);
            checkOutput($sformatf("tp%0d in_ready", i), {15'd0, inReady}, 16'd1);
            inValid = 1'b1;
            inImm   = {1'b0, v8};
            inMsb   = 4'd7;
            inMode  = 2'b00;
            @(posedge clk);
            #1;
            checkOutput($sformatf("tp%0d valid", i), {15'd0, outValid}, 16'd1);
            checkOutput($sformatf("tp%0d data", i), outData, expV);
        end
        @(negedge clk);
        inValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("tp drained", {15'd0, outValid}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
